// File: rtl/qracc_pkg.sv
// Shared types and default timing for the QRACC SRAM controller.
package qracc_pkg;

    // Default number of bitline precharge cycles
    localparam int DEF_PCH_CYC = 1;
    // Default number of wordline-active cycles before write completion or sense
    localparam int DEF_WL_CYC  = 1;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRECH  = 2'd1,
        ACCESS = 2'd2,
        SENSE  = 2'd3
    } sram_ctrl_state_t;

    // Larger of two integers, used to size the phase counter
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/qracc_wl_decoder.sv
// One-hot wordline decoder: row address to one-hot wordline vector, gated by en.
module qracc_wl_decoder #(
    parameter int numRows = 128
) (
    input  logic [$clog2(numRows)-1:0] addr,
    input  logic                       en,
    output logic [numRows-1:0]         wl
);

    localparam int AW = $clog2(numRows);

    genvar gi;
    generate
        for (gi = 0; gi < numRows; gi++) begin : g_row
            assign wl[gi] = en && (addr == AW'(gi));
        end
    endgenerate

endmodule

// File: rtl/qracc_sram_ctrl.sv
// QRACC SRAM controller: accepts read/write requests and sequences the
// analog SRAM controls (precharge, wordline, write drive, sense enable).
// Optional build macro QRACC_SRAM_WR_VERIFY_EN adds a read-back verify after
// every write and a sticky wr_err_o flag.
module qracc_sram_ctrl
    import qracc_pkg::*;
#(
    parameter int numRows = 128,
    parameter int numCols = 32,
    parameter int PCH_CYC = DEF_PCH_CYC,
    parameter int WL_CYC  = DEF_WL_CYC
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rq_wr_i,
    input  logic                       rq_valid_i,
    output logic                       rq_ready_o,
    output logic                       rd_valid_o,
    output logic [numCols-1:0]         rd_data_o,
    input  logic [numCols-1:0]         wr_data_i,
    input  logic [$clog2(numRows)-1:0] addr_i,
    output logic [numRows-1:0]         WL,
    output logic                       PCH,
    output logic [numCols-1:0]         WR_DATA,
    output logic                       WRITE,
    output logic [numCols-1:0]         CSEL,
    output logic                       SAEN,
`ifdef QRACC_SRAM_WR_VERIFY_EN
    output logic                       wr_err_o,
`endif
    input  logic [numCols-1:0]         SA_OUT
);

    localparam int AW       = $clog2(numRows);
    localparam int CNT_MAX  = max2(PCH_CYC, WL_CYC);
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PCH_LAST = CNT_W'(PCH_CYC - 1);
    localparam logic [CNT_W-1:0] WL_LAST  = CNT_W'(WL_CYC - 1);

    // Bundle of everything that goes to the analog macro
    typedef struct packed {
        logic [numRows-1:0] wl;
        logic               pch;
        logic [numCols-1:0] wr_data;
        logic               write;
        logic [numCols-1:0] csel;
        logic               saen;
    } to_analog_t;

    // Bundle of everything that comes back from the analog macro
    typedef struct packed {
        logic [numCols-1:0] sa_out;
    } from_analog_t;

    sram_ctrl_state_t   state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [AW-1:0]      addr_reg;
    logic [numCols-1:0] data_reg;
    logic               wr_reg;
    logic               rd_valid_reg;
    logic [numCols-1:0] rd_data_reg;
    to_analog_t         ana_reg;
    from_analog_t       from_ana;
    logic [numRows-1:0] dec_wl;
    logic               do_write;

`ifdef QRACC_SRAM_WR_VERIFY_EN
    logic verify_reg;
    logic err_reg;
    // The second (verify) pass of a write is a pure read of the same row
    assign do_write = wr_reg && !verify_reg;
    assign wr_err_o = err_reg;
`else
    assign do_write = wr_reg;
`endif

    assign from_ana.sa_out = SA_OUT;

    assign WL      = ana_reg.wl;
    assign PCH     = ana_reg.pch;
    assign WR_DATA = ana_reg.wr_data;
    assign WRITE   = ana_reg.write;
    assign CSEL    = ana_reg.csel;
    assign SAEN    = ana_reg.saen;

    assign rq_ready_o = (state_reg == IDLE) && !rst;
    assign rd_valid_o = rd_valid_reg;
    assign rd_data_o  = rd_data_reg;

    // Decode is only needed while precharging, where the wordline is loaded
    qracc_wl_decoder #(
        .numRows(numRows)
    ) u_wl_decoder (
        .addr(addr_reg),
        .en  (state_reg == PRECH),
        .wl  (dec_wl)
    );

    // Sequencer: state, phase counter, latched request and registered analog controls
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            addr_reg     <= '0;
            data_reg     <= '0;
            wr_reg       <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
            ana_reg      <= '0;
`ifdef QRACC_SRAM_WR_VERIFY_EN
            verify_reg   <= 1'b0;
            err_reg      <= 1'b0;
`endif
        end else begin
            rd_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (rq_valid_i) begin
                        addr_reg    <= addr_i;
                        data_reg    <= wr_data_i;
                        wr_reg      <= rq_wr_i;
                        cnt_reg     <= '0;
                        ana_reg.pch <= 1'b1;
                        state_reg   <= PRECH;
                    end
                end
                PRECH: begin
                    if (cnt_reg == PCH_LAST) begin
                        cnt_reg         <= '0;
                        ana_reg.pch     <= 1'b0;
                        ana_reg.wl      <= dec_wl;
                        ana_reg.csel    <= '1;
                        ana_reg.write   <= do_write;
                        ana_reg.wr_data <= do_write ? data_reg : '0;
                        state_reg       <= ACCESS;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt_reg == WL_LAST) begin
                        cnt_reg <= '0;
                        if (do_write) begin
`ifdef QRACC_SRAM_WR_VERIFY_EN
                            // Re-precharge and read the row back before going idle
                            ana_reg     <= '0;
                            ana_reg.pch <= 1'b1;
                            verify_reg  <= 1'b1;
                            state_reg   <= PRECH;
`else
                            ana_reg   <= '0;
                            state_reg <= IDLE;
`endif
                        end else begin
                            // Keep WL and CSEL, fire the sense amps
                            ana_reg.saen <= 1'b1;
                            state_reg    <= SENSE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                SENSE: begin
                    ana_reg   <= '0;
                    state_reg <= IDLE;
`ifdef QRACC_SRAM_WR_VERIFY_EN
                    if (verify_reg) begin
                        verify_reg <= 1'b0;
                        if (from_ana.sa_out != data_reg) begin
                            err_reg <= 1'b1;
                        end
                    end else begin
                        rd_data_reg  <= from_ana.sa_out;
                        rd_valid_reg <= 1'b1;
                    end
`else
                    rd_data_reg  <= from_ana.sa_out;
                    rd_valid_reg <= 1'b1;
`endif
                end
                default: begin
                    ana_reg   <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qracc_sram_ctrl.sv
// Self-checking bench for qracc_sram_ctrl: a behavioural SRAM array answers the
// analog controls, and a transaction-level memory model predicts read data and
// the per-cycle control timeline.
module tb_qracc_sram_ctrl;

    localparam int NR = 128;
    localparam int NC = 32;
    localparam int P  = 1;
    localparam int W  = 1;
    localparam int AW = $clog2(NR);
`ifdef QRACC_SRAM_WR_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rq_wr = 1'b0;
    logic          rq_valid = 1'b0;
    logic [NC-1:0] wr_data = '0;
    logic [AW-1:0] addr = '0;
    logic          rq_ready;
    logic          rd_valid;
    logic [NC-1:0] rd_data;
    logic [NR-1:0] wl;
    logic          pch;
    logic [NC-1:0] wr_drv;
    logic          write_en;
    logic [NC-1:0] csel;
    logic          saen;
    logic [NC-1:0] sa_out;
`ifdef QRACC_SRAM_WR_VERIFY_EN
    logic          wr_err;
`endif

    // Behavioural SRAM array and its preload port
    logic [NC-1:0] sram_arr [NR];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_row = '0;
    logic [NC-1:0] pre_val = '0;
    bit            flip_rd = 1'b0;

    // Transaction-level reference
    logic [NC-1:0] ref_mem [NR];
    logic [NC-1:0] last_rd = '0;
    bit            ref_err = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    qracc_sram_ctrl #(
        .numRows(NR), .numCols(NC), .PCH_CYC(P), .WL_CYC(W)
    ) dut (
        .clk(clk), .rst(rst), .rq_wr_i(rq_wr), .rq_valid_i(rq_valid),
        .rq_ready_o(rq_ready), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .wr_data_i(wr_data), .addr_i(addr), .WL(wl), .PCH(pch),
        .WR_DATA(wr_drv), .WRITE(write_en), .CSEL(csel), .SAEN(saen),
`ifdef QRACC_SRAM_WR_VERIFY_EN
        .wr_err_o(wr_err),
`endif
        .SA_OUT(sa_out)
    );

    // SRAM array: preload from the bench, store on WRITE at the selected row
    always @(posedge clk) begin
        if (pre_en) sram_arr[pre_row] <= pre_val;
        if (write_en) begin
            for (int r = 0; r < NR; r++) begin
                if (wl[r]) sram_arr[r] <= wr_drv;
            end
        end
    end

    // Sense amps return the selected row, optionally with bit 0 corrupted
    always_comb begin
        sa_out = '0;
        for (int r = 0; r < NR; r++) begin
            if (wl[r]) sa_out = sram_arr[r];
        end
        if (flip_rd) sa_out[0] = ~sa_out[0];
    end

    task automatic chk(input string tag, input logic [NR-1:0] act, input logic [NR-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, rq_ready, 1'b0);
        chk({tag, "_rd_valid"}, rd_valid, 1'b0);
        chk({tag, "_rd_data"}, rd_data, '0);
        chk({tag, "_wl"}, wl, '0);
        chk({tag, "_pch"}, pch, 1'b0);
        chk({tag, "_write"}, write_en, 1'b0);
        chk({tag, "_wr_data"}, wr_drv, '0);
        chk({tag, "_csel"}, csel, '0);
        chk({tag, "_saen"}, saen, 1'b0);
    endtask

    // One request from the IDLE cycle through to the next IDLE cycle, checked cycle by cycle
    task automatic txn(input bit wr, input logic [AW-1:0] a, input logic [NC-1:0] d);
        int total;
        int kk;
        bit second;
        bit e_pch, e_acc, e_sense, e_wrt;
        logic [NR-1:0] e_wl;
        chk("ready_pre", rq_ready, 1'b1);
        rq_valid = 1'b1;
        rq_wr    = wr;
        addr     = a;
        wr_data  = d;
        @(posedge clk); #1;
        e_wl = '0;
        e_wl[a] = 1'b1;
        if (wr) total = VER ? 2 * (P + W) + 1 : P + W;
        else    total = P + W + 1;
        for (int k = 1; k <= total; k++) begin
            // Busy cycles: scramble the request inputs, they must be ignored
            rq_valid = 1'($urandom);
            rq_wr    = 1'($urandom);
            addr     = AW'($urandom);
            wr_data  = $urandom;
            second  = wr && VER && (k > P + W);
            kk      = second ? k - (P + W) : k;
            e_pch   = (kk <= P);
            e_acc   = (kk > P) && (kk <= P + W);
            e_sense = (kk == P + W + 1);
            e_wrt   = e_acc && wr && !second;
            chk("pch", pch, e_pch);
            chk("wl", wl, (e_acc || e_sense) ? e_wl : '0);
            chk("wl_onehot", ($countones(wl) <= 1), 1'b1);
            chk("csel", csel, (e_acc || e_sense) ? {NC{1'b1}} : {NC{1'b0}});
            chk("write", write_en, e_wrt);
            chk("wr_data", wr_drv, e_wrt ? d : '0);
            chk("saen", saen, e_sense);
            chk("ready_busy", rq_ready, 1'b0);
            chk("rd_valid_busy", rd_valid, 1'b0);
            @(posedge clk); #1;
        end
        rq_valid = 1'b0;
        if (wr) begin
            ref_mem[a] = d;
            if (VER && flip_rd) ref_err = 1'b1;
        end else begin
            last_rd = ref_mem[a];
        end
        chk("ready_done", rq_ready, 1'b1);
        chk("rd_valid", rd_valid, !wr);
        chk("rd_data", rd_data, last_rd);
        chk("wl_idle", wl, '0);
        chk("pch_idle", pch, 1'b0);
`ifdef QRACC_SRAM_WR_VERIFY_EN
        chk("wr_err", wr_err, ref_err);
`endif
        $display("txn %s addr=%0d data=%0h rd_data=%0h", wr ? "WR" : "RD", a, d, rd_data);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] e_wl;
        // Preload array and reference while reset is held
        rst = 1'b1;
        @(posedge clk); #1;
        for (int r = 0; r < NR; r++) begin
            ref_mem[r] = (r == NR - 1) ? 32'hDEAD_BEEF : $urandom;
            pre_en  = 1'b1;
            pre_row = AW'(r);
            pre_val = ref_mem[r];
            @(posedge clk); #1;
        end
        pre_en = 1'b0;

        // Reset: three more cycles, everything quiet
        repeat (3) begin @(posedge clk); #1; end
        check_all_zero("rst");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", rq_ready, 1'b1);
        $display("reset done ready=%0b", rq_ready);

        // Directed write and read
        txn(1'b1, AW'(5), 32'hA5A5_0F0F);
        txn(1'b0, AW'(127), 32'h0);
        chk("dir_rd_data", rd_data, 32'hDEAD_BEEF);
        txn(1'b0, AW'(5), 32'h0);
        chk("dir_rd_back", rd_data, 32'hA5A5_0F0F);

        // Back-to-back reads: second accept in the rd_valid cycle
        txn(1'b0, AW'($urandom_range(0, NR - 1)), 32'h0);
        txn(1'b0, AW'($urandom_range(0, NR - 1)), 32'h0);

        // Random traffic over a small address window so reads hit earlier writes
        for (int i = 0; i < 40; i++) begin
            txn(1'($urandom), AW'($urandom_range(0, 15)), $urandom);
        end
        txn(1'b0, AW'(0), 32'h0);
        txn(1'b0, AW'(NR - 1), 32'h0);

        // Abort a read during ACCESS
        rq_valid = 1'b1;
        rq_wr    = 1'b0;
        addr     = AW'(9);
        @(posedge clk); #1;
        rq_valid = 1'b0;
        repeat (P) begin @(posedge clk); #1; end
        e_wl = '0;
        e_wl[9] = 1'b1;
        chk("abort_in_access", wl, e_wl);
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("abort");
        rst = 1'b0;
        last_rd = '0;
        ref_err = 1'b0;
        @(posedge clk); #1;
        chk("abort_ready", rq_ready, 1'b1);
        chk("abort_no_valid", rd_valid, 1'b0);
        $display("abort done rd_data=%0h", rd_data);
        txn(1'b0, AW'(9), 32'h0);

`ifdef QRACC_SRAM_WR_VERIFY_EN
        // Verify path: clean write leaves the flag low, corrupted readback sets it
        txn(1'b1, AW'(20), 32'h1234_5678);
        flip_rd = 1'b1;
        txn(1'b1, AW'(21), 32'hFFFF_FFFF);
        flip_rd = 1'b0;
        chk("verify_err", wr_err, 1'b1);
        txn(1'b0, AW'(20), 32'h0);
        txn(1'b1, AW'(22), 32'h0000_0001);
        chk("verify_sticky", wr_err, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
